// File: rtl/control_pipe.sv
// Registered instruction decoder with handshakes, load-use bubble insertion,
// multicycle MULT occupancy and illegal-encoding flagging; 1-cycle latency.
module control_pipe #(
  parameter int REG_AW   = 5,
  parameter int ALU_OPW  = 3,
  parameter int MULT_LAT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [REG_AW-1:0]  rs,
  output logic [REG_AW-1:0]  rt,
  output logic [REG_AW-1:0]  rd,
  output logic               rf_we,
  output logic               sel_mux1,
  output logic               sel_mux2,
  output logic               ram_we,
  output logic [ALU_OPW-1:0] alu_op,
  output logic               illegal,
  output logic               busy
);

  localparam logic [5:0] OP_NOP = 6'd0;
  localparam logic [5:0] OP_R   = 6'd6;
  localparam logic [5:0] OP_LW  = 6'd7;
  localparam logic [5:0] OP_SW  = 6'd8;

  localparam logic [5:0] FN_ADD  = 6'd32;
  localparam logic [5:0] FN_SUB  = 6'd34;
  localparam logic [5:0] FN_AND  = 6'd36;
  localparam logic [5:0] FN_OR   = 6'd37;
  localparam logic [5:0] FN_MULT = 6'd50;

  localparam logic [ALU_OPW-1:0] ALU_ADD  = ALU_OPW'(1);
  localparam logic [ALU_OPW-1:0] ALU_SUB  = ALU_OPW'(2);
  localparam logic [ALU_OPW-1:0] ALU_MULT = ALU_OPW'(3);
  localparam logic [ALU_OPW-1:0] ALU_AND  = ALU_OPW'(4);
  localparam logic [ALU_OPW-1:0] ALU_OR   = ALU_OPW'(5);

  typedef enum logic [1:0] {IDLE, MULT_WAIT, BUBBLE} state_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  logic              ld_vld;
  logic [REG_AW-1:0] ld_reg;

  logic [5:0]        opcode, funct;
  logic [4:0]        fld_rs, fld_rt, fld_rd;
  logic [REG_AW-1:0] f_rs, f_rt, f_rd;
  logic              is_rtype, is_lw, is_sw, is_mult;
  logic              hazard, accept;

  logic               d_rf_we, d_sel_mux1, d_sel_mux2, d_ram_we, d_illegal;
  logic [ALU_OPW-1:0] d_alu_op;

  logic unused_shamt;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign fld_rs = instr[25:21];
  assign fld_rt = instr[20:16];
  assign fld_rd = instr[15:11];
  assign f_rs   = fld_rs[4 -: REG_AW];
  assign f_rt   = fld_rt[4 -: REG_AW];
  assign f_rd   = fld_rd[4 -: REG_AW];
  assign unused_shamt = ^instr[10:6];

  assign is_rtype = (opcode == OP_R);
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign is_mult  = is_rtype && (funct == FN_MULT);

  always_comb begin
    d_rf_we    = 1'b0;
    d_sel_mux1 = 1'b0;
    d_sel_mux2 = 1'b0;
    d_ram_we   = 1'b0;
    d_alu_op   = '0;
    d_illegal  = 1'b0;
    case (opcode)
      // opcode 0 is only legal as the all-zero NOP word
      OP_NOP: d_illegal = (instr != 32'd0);
      OP_LW: begin
        d_rf_we    = 1'b1;
        d_sel_mux1 = 1'b1;
        d_sel_mux2 = 1'b1;
        d_alu_op   = ALU_ADD;
      end
      OP_SW: begin
        d_sel_mux2 = 1'b1;
        d_ram_we   = 1'b1;
        d_alu_op   = ALU_ADD;
      end
      OP_R: begin
        d_rf_we = 1'b1;
        case (funct)
          FN_ADD:  d_alu_op = ALU_ADD;
          FN_SUB:  d_alu_op = ALU_SUB;
          FN_MULT: d_alu_op = ALU_MULT;
          FN_AND:  d_alu_op = ALU_AND;
          FN_OR:   d_alu_op = ALU_OR;
          default: begin
            d_rf_we   = 1'b0;
            d_illegal = 1'b1;
          end
        endcase
      end
      default: d_illegal = 1'b1;
    endcase
  end

  // rt only counts as a source for instructions that actually read it
  assign hazard = in_valid && ld_vld && (ld_reg != '0) &&
                  ((ld_reg == f_rs) || ((is_rtype || is_sw) && (ld_reg == f_rt)));

  assign in_ready = rst_n && (state == IDLE) && !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state == MULT_WAIT) || (state == BUBBLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (hazard) begin
          state_nxt = BUBBLE;
        end else if (accept && is_mult) begin
          cnt_nxt = 4'(MULT_LAT - 1);
          if (MULT_LAT > 1) state_nxt = MULT_WAIT;
        end
      end
      MULT_WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt <= 4'd1) state_nxt = IDLE;
      end
      BUBBLE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ld_vld <= 1'b0;
      ld_reg <= '0;
    end else if (accept) begin
      ld_vld <= is_lw;
      ld_reg <= f_rt;
    end else if ((state == IDLE) && hazard) begin
      ld_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      rs        <= '0;
      rt        <= '0;
      rd        <= '0;
      rf_we     <= 1'b0;
      sel_mux1  <= 1'b0;
      sel_mux2  <= 1'b0;
      ram_we    <= 1'b0;
      alu_op    <= '0;
      illegal   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      rs        <= f_rs;
      rt        <= f_rt;
      rd        <= f_rd;
      rf_we     <= d_rf_we;
      sel_mux1  <= d_sel_mux1;
      sel_mux2  <= d_sel_mux2;
      ram_we    <= d_ram_we;
      alu_op    <= d_alu_op;
      illegal   <= d_illegal;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_control_pipe.sv
// Directed bench for control_pipe: scoreboard of decoded words plus cycle-exact
// handshake, bubble, MULT occupancy, backpressure and reset checks.
module tb_control_pipe;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr;
  logic [4:0]  rs, rt, rd;
  logic        rf_we, sel_mux1, sel_mux2, ram_we, illegal, busy;
  logic [2:0]  alu_op;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [4:0] rs, rt, rd;
    logic       rf_we, s1, s2, ram_we;
    logic [2:0] alu;
    logic       ill;
  } exp_t;

  exp_t q[$];

  control_pipe #(.REG_AW(5), .ALU_OPW(3), .MULT_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .out_valid(out_valid), .out_ready(out_ready),
    .rs(rs), .rt(rt), .rd(rd), .rf_we(rf_we), .sel_mux1(sel_mux1),
    .sel_mux2(sel_mux2), .ram_we(ram_we), .alu_op(alu_op),
    .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] i);
    exp_t e;
    e    = '0;
    e.rs = i[25:21];
    e.rt = i[20:16];
    e.rd = i[15:11];
    case (i[31:26])
      6'd0: e.ill = (i != 32'd0);
      6'd7: begin e.rf_we = 1'b1; e.s1 = 1'b1; e.s2 = 1'b1; e.alu = 3'd1; end
      6'd8: begin e.s2 = 1'b1; e.ram_we = 1'b1; e.alu = 3'd1; end
      6'd6: begin
        e.rf_we = 1'b1;
        case (i[5:0])
          6'd32:   e.alu = 3'd1;
          6'd34:   e.alu = 3'd2;
          6'd50:   e.alu = 3'd3;
          6'd36:   e.alu = 3'd4;
          6'd37:   e.alu = 3'd5;
          default: begin e.rf_we = 1'b0; e.ill = 1'b1; end
        endcase
      end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare the held output against the oldest accepted word,
  // retire it on an output transfer, then queue the word accepted this edge.
  task automatic mon();
    exp_t got;
    if (!rst_n) begin
      q.delete();
    end else begin
      if (out_valid) begin
        got = {rs, rt, rd, rf_we, sel_mux1, sel_mux2, ram_we, alu_op, illegal};
        chk("sb_depth", 32'(q.size()), 32'd1);
        if (q.size() > 0) begin
          chk("sb_out", 32'(got), 32'(q[0]));
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) q.push_back(model(instr));
    end
  endtask

  task automatic step();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; instr = 32'h1C000000; out_ready = 1'b1;
    #1 chk("rst_in_ready0", 32'(in_ready), 32'd0);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("rst_outs", 32'({out_valid, rs, rt, rd, rf_we, sel_mux1, sel_mux2,
                           ram_we, alu_op, illegal, busy}), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
    end
    rst_n = 1'b1; in_valid = 1'b0;
    step();
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    chk("rel_out_valid", 32'(out_valid), 32'd0);

    // LW with rt=0 followed by ADD: no bubble
    in_valid = 1'b1; instr = 32'h1C000000;
    #1 chk("lw0_rdy", 32'(in_ready), 32'd1);
    step();
    instr = 32'h180002A0;
    #1 chk("add0_rdy", 32'(in_ready), 32'd1);
    chk("lw0_ctl", 32'({out_valid, rf_we, sel_mux1, sel_mux2, ram_we, alu_op}), 32'b1_1110_001);
    step();
    in_valid = 1'b0;
    #1 chk("add0_ctl", 32'({out_valid, rf_we, sel_mux1, sel_mux2, alu_op}), 32'b1_100_001);
    step();
    chk("drain_vld", 32'(out_valid), 32'd0);

    // all-zero NOP
    in_valid = 1'b1; instr = 32'h00000000;
    step();
    in_valid = 1'b0;
    #1 chk("nop_ctl", 32'({out_valid, rf_we, sel_mux1, sel_mux2, ram_we, alu_op, illegal}), 32'h100);
    step();

    // load-use on rs: one bubble cycle
    in_valid = 1'b1; instr = 32'h1C030000;
    step();
    instr = 32'h18601020;
    #1 chk("haz_rdy", 32'(in_ready), 32'd0);
    chk("haz_busy", 32'(busy), 32'd0);
    step();
    chk("bub_rdy", 32'(in_ready), 32'd0);
    chk("bub_busy", 32'(busy), 32'd1);
    step();
    chk("post_bub_rdy", 32'(in_ready), 32'd1);
    chk("post_bub_busy", 32'(busy), 32'd0);
    step();
    in_valid = 1'b0;
    chk("add3_out", 32'({out_valid, rd, alu_op}), 32'({1'b1, 5'd2, 3'd1}));
    step();

    // load-use through rt of SW; LW's rt is not a source
    in_valid = 1'b1; instr = 32'h1C050000;
    step();
    instr = 32'h20050000;
    #1 chk("sw_rt_haz", 32'(in_ready), 32'd0);
    step(); step(); step();
    instr = 32'h1C050000;
    step();
    instr = 32'h1C050000;
    #1 chk("lw_rt_nohaz", 32'(in_ready), 32'd1);
    step();
    instr = 32'h18000024;
    #1 chk("and_nohaz", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    step();

    // MULT occupies three further cycles
    in_valid = 1'b1; instr = 32'h180002B2;
    step();
    instr = 32'h18221825;
    #1 chk("mult_op", 32'(alu_op), 32'd3);
    for (int k = 0; k < 3; k++) begin
      chk("mult_rdy", 32'(in_ready), 32'd0);
      chk("mult_busy", 32'(busy), 32'd1);
      step();
    end
    chk("mult_done_rdy", 32'(in_ready), 32'd1);
    chk("mult_done_busy", 32'(busy), 32'd0);
    step();
    in_valid = 1'b0;
    chk("or_out", 32'({out_valid, alu_op}), 32'({1'b1, 3'd5}));
    step();

    // SW held under backpressure, then transfer and accept together
    in_valid = 1'b1; instr = 32'h20000000;
    step();
    instr = 32'h18000024; out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1 chk("bp_rdy", 32'(in_ready), 32'd0);
      chk("bp_hold", 32'({out_valid, ram_we, alu_op}), 32'({1'b1, 1'b1, 3'd1}));
      step();
    end
    out_ready = 1'b1;
    #1 chk("bp_rel_rdy", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp_next", 32'({out_valid, ram_we, alu_op}), 32'({1'b1, 1'b0, 3'd4}));
    step();

    // illegal funct, then illegal opcode
    in_valid = 1'b1; instr = 32'h180002A6;
    step();
    instr = 32'h24221800;
    #1 chk("ill_funct", 32'({out_valid, illegal, rf_we, ram_we, alu_op}), 32'({4'b1100, 3'd0}));
    step();
    in_valid = 1'b0;
    #1 chk("ill_op", 32'({out_valid, illegal, rf_we, ram_we, alu_op}), 32'({4'b1100, 3'd0}));
    chk("ill_fields", 32'({rs, rt, rd}), 32'({5'd1, 5'd2, 5'd3}));
    step();

    // reset while in MULT_WAIT
    in_valid = 1'b1; instr = 32'h180002B2;
    step();
    in_valid = 1'b0;
    step();
    chk("mw_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1 chk("mw_rst_rdy", 32'(in_ready), 32'd0);
    step();
    chk("mw_rst_outs", 32'({out_valid, busy, in_ready}), 32'd0);
    rst_n = 1'b1;
    #1 chk("mw_rel_rdy", 32'(in_ready), 32'd1);
    chk("mw_rel_busy", 32'(busy), 32'd0);
    step();
    step();

    chk("sb_drain", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
